// File: rtl/dmem_pkg.sv
// Shared encodings for the sized data memory: access sizes, FSM states and
// wait-state limits.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int WAIT_MIN = 0;
  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } dmem_state_e;

endpackage

// File: rtl/dmem_sized_if.sv
// Request/response bus between a MEM-stage master and the sized data memory.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready. While a
// valid is high without its ready, the presenting side holds its payload stable.
interface dmem_sized_if #(
  parameter int ADDR_W = 7
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Big-endian lane steering: alignment check, load extract/extend and
// store merge into the old word. Purely combinational.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic        err,
  output logic [31:0] load_data,
  output logic [31:0] new_word
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    // Offset 0 is the most significant lane, so shift = (3 - offset) * 8.
    byte_sh   = {~offset, 3'b000};
    half_sh   = {~offset[1], 4'b0000};
    byte_v    = old_word[byte_sh +: 8];
    half_v    = old_word[half_sh +: 16];
    err       = 1'b0;
    load_data = '0;
    new_word  = old_word;

    case (size)
      SZ_BYTE: begin
        load_data = {{24{sign_ext & byte_v[7]}}, byte_v};
        new_word[byte_sh +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        if (offset[0]) begin
          err = 1'b1;
        end else begin
          load_data = {{16{sign_ext & half_v[15]}}, half_v};
          new_word[half_sh +: 16] = wdata[15:0];
        end
      end
      SZ_WORD: begin
        if (offset != 2'b00) begin
          err = 1'b1;
        end else begin
          load_data = old_word;
          new_word  = wdata;
        end
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_sized.sv
// Single-port sized data memory with valid/ready request/response,
// programmable wait states and misalignment reporting.
module dmem_sized
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int WAIT   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_sized_if.slave bus,
  output dmem_state_e dbg_state
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);
  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT);

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  // Storage holds (data XOR base address) so an all-zero array reads back
  // as the power-up image where word i equals i*4.
  logic [31:0]       mem_q [DEPTH];
  logic              mem_we;
  logic [31:0]       img_word;
  logic [31:0]       old_word;
  logic              align_err;
  logic [31:0]       load_data;
  logic [31:0]       new_word;

  assign img_word = 32'({addr_q[ADDR_W-1:2], 2'b00});
  assign old_word = mem_q[addr_q[ADDR_W-1:2]] ^ img_word;

  dmem_lane_align u_align (
    .size      (size_q),
    .offset    (addr_q[1:0]),
    .sign_ext  (signed_q),
    .old_word  (old_word),
    .wdata     (wdata_q),
    .err       (align_err),
    .load_data (load_data),
    .new_word  (new_word)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mem_we   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d     = bus.req_we;
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          cnt_d    = WAIT_CNT;
          state_d  = (WAIT > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        // Errored requests and stores both return zero data.
        err_d   = align_err;
        rdata_d = (we_q || align_err) ? 32'h0 : load_data;
        mem_we  = we_q & ~align_err;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr_q[ADDR_W-1:2]] <= new_word ^ img_word;
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_dmem_sized.sv
// Bench for dmem_sized: two instances (WAIT=0 and WAIT=3) checked against a
// byte-addressed big-endian reference memory.
module tb_dmem_sized;
  import dmem_pkg::*;

  localparam int AW   = 7;
  localparam int NDUT = 2;
  localparam int WAIT_CFG [NDUT] = '{0, 3};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              req_valid  [NDUT];
  logic              req_we     [NDUT];
  logic              req_signed [NDUT];
  logic              rsp_ready  [NDUT];
  logic [1:0]        req_size   [NDUT];
  logic [AW-1:0]     req_addr   [NDUT];
  logic [31:0]       req_wdata  [NDUT];
  logic              req_ready  [NDUT];
  logic              rsp_valid  [NDUT];
  logic              rsp_err    [NDUT];
  logic [31:0]       rsp_rdata  [NDUT];
  dmem_state_e       dbg_state  [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_sized_if #(.ADDR_W(AW)) bus ();
    assign bus.req_valid  = req_valid[g];
    assign bus.req_we     = req_we[g];
    assign bus.req_size   = req_size[g];
    assign bus.req_signed = req_signed[g];
    assign bus.req_addr   = req_addr[g];
    assign bus.req_wdata  = req_wdata[g];
    assign bus.rsp_ready  = rsp_ready[g];
    assign req_ready[g]   = bus.req_ready;
    assign rsp_valid[g]   = bus.rsp_valid;
    assign rsp_rdata[g]   = bus.rsp_rdata;
    assign rsp_err[g]     = bus.rsp_err;

    dmem_sized #(.ADDR_W(AW), .WAIT(WAIT_CFG[g])) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .dbg_state (dbg_state[g])
    );
  end

  // Reference memory: one byte per address, big-endian within a word.
  logic [7:0]  mem_b [NDUT][2**AW];
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  logic [31:0] last_rdata;
  logic        last_err;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit ref_err(input logic [1:0] size, input logic [AW-1:0] a);
    return (size == 2'b11) || (size == 2'b01 && a[0]) || (size == 2'b10 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] ref_load(input bit d, input logic [1:0] size, input bit sgn,
                                           input logic [AW-1:0] a);
    int          n = 1 << size;
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(mem_b[d][a + AW'(i)]);
    if (n < 4 && sgn && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input bit d, input logic [1:0] size, input logic [AW-1:0] a,
                           input logic [31:0] wdata);
    int n = 1 << size;
    for (int i = 0; i < n; i++) mem_b[d][a + AW'(i)] = 8'(wdata >> (8 * (n - 1 - i)));
  endtask

  task automatic check_reset_outputs(input bit d, input string tag);
    check_eq({tag, "_req_ready"}, 32'(req_ready[d]), 32'd1);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid[d]), 32'd0);
    check_eq({tag, "_rsp_rdata"}, rsp_rdata[d], 32'h0);
    check_eq({tag, "_rsp_err"}, 32'(rsp_err[d]), 32'd0);
  endtask

  // Present one request at a negedge, accept on the next posedge, then scramble
  // the inputs to show post-accept changes are ignored. Returns at the negedge after accept.
  task automatic send(input bit d, input bit we, input logic [1:0] size, input bit sgn,
                      input logic [AW-1:0] addr, input logic [31:0] wdata);
    bit e = ref_err(size, addr);
    exp_err_q.push_back(e);
    exp_q.push_back((e || we) ? 32'h0 : ref_load(d, size, sgn, addr));
    @(negedge clk);
    check_eq("req_ready_idle", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = size;
    req_signed[d] = sgn; req_addr[d] = addr; req_wdata[d] = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_we[d] = 1'($urandom); req_size[d] = 2'($urandom); req_signed[d] = 1'($urandom);
    req_addr[d] = AW'($urandom); req_wdata[d] = $urandom;
  endtask

  // lat = index of the first edge (accept edge = 0) at which rsp_valid is sampled high.
  task automatic wait_rsp(input bit d, output int lat);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (rsp_valid[d]) begin
        lat = k + 1;
        break;
      end
      check_eq("req_ready_busy", 32'(req_ready[d]), 32'd0);
      @(negedge clk);
    end
    if (lat < 0) check_eq("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic finish_rsp(input bit d, input int hold);
    logic [31:0] e  = exp_q.pop_front();
    logic        ee = exp_err_q.pop_front();
    check_eq("rsp_rdata", rsp_rdata[d], e);
    check_eq("rsp_err", 32'(rsp_err[d]), 32'(ee));
    last_rdata = rsp_rdata[d];
    last_err   = rsp_err[d];
    for (int h = 0; h < hold; h++) begin
      req_valid[d] = 1'b1; req_we[d] = 1'($urandom); req_addr[d] = AW'($urandom);
      req_size[d] = 2'($urandom); req_wdata[d] = $urandom;
      @(negedge clk);
      check_eq("hold_valid", 32'(rsp_valid[d]), 32'd1);
      check_eq("hold_rdata", rsp_rdata[d], e);
      check_eq("hold_err", 32'(rsp_err[d]), 32'(ee));
      check_eq("hold_req_ready", 32'(req_ready[d]), 32'd0);
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    check_eq("post_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    check_eq("post_req_ready", 32'(req_ready[d]), 32'd1);
  endtask

  task automatic txn(input bit d, input bit we, input logic [1:0] size, input bit sgn,
                     input logic [AW-1:0] addr, input logic [31:0] wdata, input int hold);
    int lat;
    send(d, we, size, sgn, addr, wdata);
    wait_rsp(d, lat);
    check_eq("latency", 32'(lat), 32'(WAIT_CFG[d] + 2));
    if (lat > 0) finish_rsp(d, hold);
    else begin
      void'(exp_q.pop_front());
      void'(exp_err_q.pop_front());
    end
    if (we && !ref_err(size, addr)) ref_store(d, size, addr, wdata);
  endtask

  initial begin
    int lat;
    logic [31:0] w;
    for (int d = 0; d < NDUT; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_signed[d] = 1'b0; rsp_ready[d] = 1'b0;
      req_size[d] = 2'b00; req_addr[d] = '0; req_wdata[d] = 32'h0;
      for (int a = 0; a < 2**AW; a++) begin
        w = 32'(a) & ~32'd3;
        mem_b[d[0]][a[AW-1:0]] = 8'(w >> (8 * (3 - (a % 4))));
      end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs(1'b0, "rst0");
    check_reset_outputs(1'b1, "rst1");
    rst_n = 1'b1;

    // Directed sequence on the WAIT=0 instance.
    txn(1'b0, 1'b0, SZ_WORD, 1'b0, 7'h14, 32'h0, 0);
    check_eq("plan_powerup_0x14", last_rdata, 32'h0000_0014);
    txn(1'b0, 1'b1, SZ_WORD, 1'b0, 7'h10, 32'h8234_56F0, 0);
    txn(1'b0, 1'b0, SZ_BYTE, 1'b1, 7'h10, 32'h0, 0);
    check_eq("plan_sbyte", last_rdata, 32'hFFFF_FF82);
    txn(1'b0, 1'b0, SZ_BYTE, 1'b0, 7'h10, 32'h0, 0);
    check_eq("plan_ubyte", last_rdata, 32'h0000_0082);
    txn(1'b0, 1'b0, SZ_HALF, 1'b1, 7'h12, 32'h0, 0);
    check_eq("plan_shalf", last_rdata, 32'h0000_56F0);
    txn(1'b0, 1'b1, SZ_BYTE, 1'b0, 7'h11, 32'h0000_00AA, 0);
    txn(1'b0, 1'b0, SZ_WORD, 1'b0, 7'h10, 32'h0, 0);
    check_eq("plan_byte_merge", last_rdata, 32'h82AA_56F0);
    txn(1'b0, 1'b1, SZ_HALF, 1'b0, 7'h12, 32'h0000_BEEF, 0);
    txn(1'b0, 1'b0, SZ_WORD, 1'b0, 7'h10, 32'h0, 0);
    check_eq("plan_half_merge", last_rdata, 32'h82AA_BEEF);
    txn(1'b0, 1'b0, SZ_HALF, 1'b1, 7'h13, 32'h0, 0);
    check_eq("plan_err_half", 32'(last_err), 32'd1);
    txn(1'b0, 1'b1, SZ_WORD, 1'b0, 7'h12, 32'h1234_5678, 0);
    check_eq("plan_err_word", 32'(last_err), 32'd1);
    txn(1'b0, 1'b1, SZ_RSVD, 1'b0, 7'h10, 32'hFFFF_FFFF, 0);
    check_eq("plan_err_rsvd", 32'(last_err), 32'd1);
    txn(1'b0, 1'b0, SZ_WORD, 1'b0, 7'h10, 32'h0, 0);
    check_eq("plan_after_err", last_rdata, 32'h82AA_BEEF);

    // WAIT=3 instance with backpressure and ignored request pulses.
    txn(1'b1, 1'b0, SZ_WORD, 1'b0, 7'h14, 32'h0, 4);
    check_eq("plan_wait3_load", last_rdata, 32'h0000_0014);

    // Reset while the store is still waiting: the store must be dropped.
    send(1'b1, 1'b1, SZ_WORD, 1'b0, 7'h20, 32'hDEAD_BEEF);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(1'b1, "rst_wait");
    check_eq("rst_wait_state", 32'(dbg_state[1]), 32'(S_IDLE));
    void'(exp_q.pop_front());
    void'(exp_err_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    txn(1'b1, 1'b0, SZ_WORD, 1'b0, 7'h20, 32'h0, 0);
    check_eq("plan_rst_discard", last_rdata, 32'h0000_0020);

    // Reset while the response is pending: the store stays committed.
    w = $urandom;
    send(1'b1, 1'b1, SZ_WORD, 1'b0, 7'h24, w);
    wait_rsp(1'b1, lat);
    check_eq("latency_resp_rst", 32'(lat), 32'd5);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(1'b1, "rst_resp");
    void'(exp_q.pop_front());
    void'(exp_err_q.pop_front());
    ref_store(1'b1, SZ_WORD, 7'h24, w);
    @(negedge clk);
    rst_n = 1'b1;
    txn(1'b1, 1'b0, SZ_WORD, 1'b0, 7'h24, 32'h0, 0);
    check_eq("plan_rst_keep", last_rdata, w);

    // Randomized traffic on both instances.
    for (int it = 0; it < 80; it++) begin
      bit            d    = 1'($urandom);
      bit            we   = 1'($urandom);
      logic [1:0]    size = 2'($urandom_range(0, 3));
      logic [AW-1:0] addr = AW'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (size == SZ_HALF) addr[0] = 1'b0;
        if (size == SZ_WORD) addr[1:0] = 2'b00;
      end
      txn(d, we, size, 1'($urandom), addr, $urandom, $urandom_range(0, 2));
    end

    check_eq("final_state0", 32'(dbg_state[0]), 32'(S_IDLE));
    check_eq("final_state1", 32'(dbg_state[1]), 32'(S_IDLE));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
